dilithium_stream_host: RTL

Host-side streaming engine that sits at the other end of the Dilithium core's 32-bit valid/ready data ports. On `start` it reads `in_len` words from a source buffer and streams them to the core. Concurrently it accepts `out_len` result words from the core and writes them to a result buffer. It pulses `done` when both transfers have completed. It replaces ad-hoc testbench/host glue that drives `data_i`/`valid_i` and drains `data_o`/`valid_o`.

---
 rtl/dilithium_stream_host.sv | 98 +++++++++
 1 files changed

// File: rtl/dilithium_stream_host.sv
// dilithium_stream_host: streams a source buffer into the core's valid/ready input port
// and drains the core's output port into a result buffer, pulsing done when both finish.
module dilithium_stream_host #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_len,
    input  logic [ADDR_W-1:0] out_len,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [31:0]       src_rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [31:0]       tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       rx_data,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic [31:0]       dst_wr_data,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] in_len_q, out_len_q, rd_cnt, tx_cnt, rx_cnt;
    logic [31:0]       fifo [2];
    logic              wr_ptr, rd_ptr, in_flight;
    logic [1:0]        count;
    logic              run, pop, push, rx_fire, complete;

    always_comb begin
        run         = state == RUN;
        tx_valid    = count != 2'd0;
        tx_data     = tx_valid ? fifo[rd_ptr] : '0;
        pop         = tx_valid && tx_ready;
        push        = in_flight;
        // a slot freed by this cycle's pop can be refilled immediately, giving one word per cycle
        src_rd_en   = run && (rd_cnt < in_len_q) && ((2'(count + {1'b0, in_flight}) < 2'd2) || pop);
        src_rd_addr = rd_cnt;
        rx_ready    = run && (rx_cnt < out_len_q);
        rx_fire     = rx_valid && rx_ready;
        dst_wr_en   = rx_fire;
        dst_wr_addr = rx_fire ? rx_cnt : '0;
        dst_wr_data = rx_fire ? rx_data : '0;
        busy        = state != IDLE;
        done        = state == DONE;
        complete    = (tx_cnt == in_len_q) && (rx_cnt == out_len_q) && (count == 2'd0) && !in_flight;
        state_n     = state == IDLE ? (start ? RUN : IDLE) :
                      state == RUN  ? (complete ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_len_q  <= '0;
            out_len_q <= '0;
            rd_cnt    <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            in_flight <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                in_len_q  <= in_len;
                out_len_q <= out_len;
                rd_cnt    <= '0;
                tx_cnt    <= '0;
                rx_cnt    <= '0;
                wr_ptr    <= 1'b0;
                rd_ptr    <= 1'b0;
                count     <= 2'd0;
                in_flight <= 1'b0;
            end else begin
                in_flight <= src_rd_en;
                if (src_rd_en) rd_cnt <= rd_cnt + 1'b1;
                if (push) wr_ptr <= ~wr_ptr;
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                    tx_cnt <= tx_cnt + 1'b1;
                end
                count <= 2'(count + {1'b0, push} - {1'b0, pop});
                if (rx_fire) rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // storage needs no reset: tx_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= src_rd_data;
    end
endmodule
